cla_mp_sequencer: RTL

Multi-precision adder sequencer that time-shares one combinational 16-bit carry-lookahead adder slice (`CLA_16bits`) to add operands of `16*WORDS` bits. It processes one 16-bit chunk per clock, least-significant first, and chains the carry through a register. A valid/ready request/response handshake wraps the datapath, so the block sits between an operand source (register file or bus master) and the consumer of wide sums. Throughput is deliberately traded for area.

---
 rtl/cla_mp_sequencer_pkg.sv | 17 +
 rtl/cla_mp_sequencer_cla.sv | 52 +++++
 rtl/cla_mp_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cla_mp_sequencer_pkg.sv
// cla_mp_sequencer_pkg: shared FSM encodings, chunk width and index-width helper
// for the multi-precision CLA sequencer.
package cla_mp_sequencer_pkg;

    localparam int CLA_CHUNK = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/cla_mp_sequencer_cla.sv
// CLA_16bits: combinational 16-bit carry-lookahead adder built from four 4-bit
// lookahead groups with a second lookahead level across the groups.
module CLA_16bits
    import cla_mp_sequencer_pkg::*;
(
    input  logic [CLA_CHUNK-1:0] a,
    input  logic [CLA_CHUNK-1:0] b,
    input  logic                 cin,
    output logic [CLA_CHUNK-1:0] sum,
    output logic                 cout
);

    logic [CLA_CHUNK-1:0] g;
    logic [CLA_CHUNK-1:0] p;
    logic [CLA_CHUNK-1:0] c;
    logic [3:0]           gg;
    logic [3:0]           gp;
    logic [4:0]           gc;

    assign g = a & b;
    assign p = a ^ b;

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_grp
            localparam int B = 4 * k;
            assign gg[k] = g[B+3]
                         | (p[B+3] & g[B+2])
                         | (p[B+3] & p[B+2] & g[B+1])
                         | (p[B+3] & p[B+2] & p[B+1] & g[B]);
            assign gp[k] = &p[B +: 4];
            assign c[B]   = gc[k];
            assign c[B+1] = g[B] | (p[B] & gc[k]);
            assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
            assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                          | (p[B+2] & p[B+1] & p[B] & gc[k]);
        end
    endgenerate

    // Group carries are fully expanded so no carry ripples between groups.
    assign gc[0] = cin;
    assign gc[1] = gg[0] | (gp[0] & cin);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cin);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

    assign sum  = p ^ c;
    assign cout = gc[4];

endmodule

// File: rtl/cla_mp_sequencer.sv
// cla_mp_sequencer: adds 16*WORDS-bit operands one 16-bit CLA chunk per clock, LSB first.
// Define CLA_SEQ_SUB_EN to add the sub port (A-B via inverted B and carry-in of 1).
module cla_mp_sequencer
    import cla_mp_sequencer_pkg::*;
#(
    parameter int WORDS = 4,
    localparam int W  = CLA_CHUNK * WORDS,
    localparam int IW = idx_width(WORDS)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic         sub,
`endif
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         busy
);

    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [W-1:0]         a_q, a_d;
    logic [W-1:0]         b_q, b_d;
    logic [W-1:0]         sum_q, sum_d;
    logic                 c_q, c_d;
    logic                 cout_q, cout_d;
    logic                 ovf_q, ovf_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [W-1:0]         b_in;
    logic                 c_in;
    logic [CLA_CHUNK-1:0] s;
    logic                 co;

`ifdef CLA_SEQ_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub | cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    CLA_16bits u_cla (
        .a    (a_q[CLA_CHUNK-1:0]),
        .b    (b_q[CLA_CHUNK-1:0]),
        .cin  (c_q),
        .sum  (s),
        .cout (co)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        c_d         = c_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: if (req_valid) begin
                a_d     = a;
                b_d     = b_in;
                c_d     = c_in;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                sum_d[CLA_CHUNK*int'(idx_q) +: CLA_CHUNK] = s;
                c_d   = co;
                a_d   = a_q >> CLA_CHUNK;
                b_d   = b_q >> CLA_CHUNK;
                idx_d = idx_q + 1'b1;
                // On the top chunk the low 16 bits of the shift registers hold the operand sign bits.
                if (idx_q == LAST) begin
                    cout_d      = co;
                    ovf_d       = (a_q[CLA_CHUNK-1] == b_q[CLA_CHUNK-1]) && (s[CLA_CHUNK-1] != a_q[CLA_CHUNK-1]);
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            c_q         <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            c_q         <= c_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
